// File: rtl/fanout_release_sequencer_if.sv
// Request/acknowledge/status bundle for the fanout release sequencer.
// slave is the sequencer side, master the controller/consumer side.
interface fanout_release_sequencer_if;
    logic in_req;
    logic ack_0;
    logic ack_1;
    logic err_clr;
    logic out_0;
    logic out_1;
    logic busy;
    logic err;

    modport slave (
        input  in_req,
        input  ack_0,
        input  ack_1,
        input  err_clr,
        output out_0,
        output out_1,
        output busy,
        output err
    );

    modport master (
        output in_req,
        output ack_0,
        output ack_1,
        output err_clr,
        input  out_0,
        input  out_1,
        input  busy,
        input  err
    );
endinterface

// File: rtl/fanout_release_sequencer.sv
// Ordered, acknowledged enable/release of two consumers from one
// asynchronous request: up is out_0 then out_1, down is the reverse.
module fanout_release_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 4,
    parameter int GAP         = 8,
    parameter int TIMEOUT     = 64
) (
    input  logic clock,
    input  logic reset,
    fanout_release_sequencer_if.slave bus
);

    localparam int MAXC = (GAP > TIMEOUT) ? GAP : TIMEOUT;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int FW   = (FILTER > 1) ? $clog2(FILTER) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RISE0,
        GAP_UP,
        RISE1,
        ON,
        FALL1,
        GAP_DN,
        FALL0
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FW-1:0]          r_fcnt;
    logic                   r_f;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_first;
    logic                   r_out_0;
    logic                   r_out_1;
    logic                   r_busy;
    logic                   r_err;

    logic   w_s;
    state_t w_next;
    logic   w_tmo;
    logic   w_gap_done;
    logic   w_tmo_hit;
    logic   w_wait;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_fcnt <= '0;
            r_f    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.in_req};
            if (w_s != r_f) begin
                if (r_fcnt == FW'(FILTER - 1)) begin
                    r_f    <= w_s;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + FW'(1);
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    // The counter is held clear for the first cycle of each state.
    assign w_gap_done = !r_first && (r_cnt == CW'(GAP - 1));
    assign w_tmo_hit  = !r_first && (r_cnt == CW'(TIMEOUT - 1));
    assign w_wait     = (r_state != IDLE) && (r_state != ON);

    always_comb begin
        w_next = r_state;
        w_tmo  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_f) w_next = RISE0;
            end
            RISE0: begin
                if (!r_f) begin
                    w_next = FALL0;
                end else if (bus.ack_0) begin
                    w_next = GAP_UP;
                end else if (w_tmo_hit) begin
                    w_next = GAP_UP;
                    w_tmo  = 1'b1;
                end
            end
            GAP_UP: begin
                if (!r_f)            w_next = FALL0;
                else if (w_gap_done) w_next = RISE1;
            end
            RISE1: begin
                if (!r_f) begin
                    w_next = FALL1;
                end else if (bus.ack_1) begin
                    w_next = ON;
                end else if (w_tmo_hit) begin
                    w_next = ON;
                    w_tmo  = 1'b1;
                end
            end
            ON: begin
                if (!r_f) w_next = FALL1;
            end
            FALL1: begin
                if (!bus.ack_1) begin
                    w_next = GAP_DN;
                end else if (w_tmo_hit) begin
                    w_next = GAP_DN;
                    w_tmo  = 1'b1;
                end
            end
            GAP_DN: begin
                if (w_gap_done) w_next = FALL0;
            end
            FALL0: begin
                if (!bus.ack_0) begin
                    w_next = IDLE;
                end else if (w_tmo_hit) begin
                    w_next = IDLE;
                    w_tmo  = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_first <= 1'b1;
            r_out_0 <= 1'b0;
            r_out_1 <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt   <= '0;
                r_first <= 1'b1;
            end else if (r_first) begin
                r_first <= 1'b0;
            end else if (w_wait) begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_out_0 <= (w_next != IDLE) && (w_next != FALL0);
            r_out_1 <= (w_next == RISE1) || (w_next == ON);
            r_busy  <= (w_next != IDLE) && (w_next != ON);
            if (w_tmo)            r_err <= 1'b1;
            else if (bus.err_clr) r_err <= 1'b0;
        end
    end

    assign bus.out_0 = r_out_0;
    assign bus.out_1 = r_out_1;
    assign bus.busy  = r_busy;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_fanout_release_sequencer.sv
// Directed bench for fanout_release_sequencer: timed vector table plus
// hand-written timeout, abort and reset sequences.
module tb_fanout_release_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    fanout_release_sequencer_if bus ();

    fanout_release_sequencer #(
        .SYNC_STAGES(2),
        .FILTER(4),
        .GAP(8),
        .TIMEOUT(64)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int         cyc;
        logic       req;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [22];

    int   cyc;
    int   n_run;
    int   n_fail;
    bit   auto0;
    bit   auto1;
    bit   saw1;
    logic [3:0] d0;
    logic [3:0] d1;

    function automatic logic [3:0] outs();
        return {bus.out_0, bus.out_1, bus.busy, bus.err};
    endfunction

    // Consumers echo their enable 3 cycles later when in auto mode.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        d0 = {d0[2:0], bus.out_0};
        d1 = {d1[2:0], bus.out_1};
        if (auto0) bus.ack_0 = d0[3];
        if (auto1) bus.ack_1 = d1[3];
        saw1 = saw1 | bus.out_1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %b want %b",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        bus.in_req  = 1'b0;
        bus.ack_0   = 1'b0;
        bus.ack_1   = 1'b0;
        bus.err_clr = 1'b0;
        auto0       = 1'b1;
        auto1       = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        cyc  = 0;
        saw1 = 1'b0;
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        cyc = 0;
        d0 = '0;
        d1 = '0;
        saw1 = 1'b0;
        // {o0,o1,busy,err}; req is driven after the check
        tbl[0]  = '{0,  1'b1, 4'b0000};
        tbl[1]  = '{6,  1'b1, 4'b0000};
        tbl[2]  = '{7,  1'b1, 4'b1010};
        tbl[3]  = '{19, 1'b1, 4'b1010};
        tbl[4]  = '{20, 1'b1, 4'b1110};
        tbl[5]  = '{23, 1'b1, 4'b1110};
        tbl[6]  = '{24, 1'b1, 4'b1100};
        tbl[7]  = '{30, 1'b0, 4'b1100};
        tbl[8]  = '{36, 1'b0, 4'b1100};
        tbl[9]  = '{37, 1'b0, 4'b1010};
        tbl[10] = '{49, 1'b0, 4'b1010};
        tbl[11] = '{50, 1'b0, 4'b0010};
        tbl[12] = '{53, 1'b0, 4'b0010};
        tbl[13] = '{54, 1'b0, 4'b0000};
        tbl[14] = '{60, 1'b1, 4'b0000};
        tbl[15] = '{63, 1'b0, 4'b0000};
        tbl[16] = '{80, 1'b1, 4'b0000};
        tbl[17] = '{84, 1'b0, 4'b0000};
        tbl[18] = '{86, 1'b0, 4'b0000};
        tbl[19] = '{87, 1'b0, 4'b1010};
        tbl[20] = '{91, 1'b0, 4'b0010};
        tbl[21] = '{95, 1'b0, 4'b0000};

        do_reset();
        for (int i = 0; i < 22; i++) begin
            run_to(tbl[i].cyc);
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
            bus.in_req = tbl[i].req;
        end

        // ack_0 never answers: timeout, err, sequence continues
        do_reset();
        auto0 = 1'b0;
        bus.ack_0 = 1'b0;
        bus.in_req = 1'b1;
        run_to(7);
        chk("tmo_out0", outs(), 4'b1010);
        run_to(71);
        chk("tmo_pre", outs(), 4'b1010);
        run_to(72);
        chk("tmo_err", outs(), 4'b1011);
        run_to(80);
        chk("tmo_gap", outs(), 4'b1011);
        run_to(81);
        chk("tmo_out1", outs(), 4'b1111);
        run_to(85);
        chk("tmo_on", outs(), 4'b1101);
        run_to(90);
        chk("err_sticky", outs(), 4'b1101);
        bus.err_clr = 1'b1;
        run_to(91);
        bus.err_clr = 1'b0;
        chk("err_clr", outs(), 4'b1100);

        // abort in GAP_UP, re-raise while FALL0 is held
        do_reset();
        bus.in_req = 1'b1;
        run_to(11);
        bus.in_req = 1'b0;
        run_to(17);
        chk("abort_gap", outs(), 4'b1010);
        run_to(18);
        chk("abort_fall0", outs(), 4'b0010);
        auto0 = 1'b0;
        bus.ack_0 = 1'b1;
        bus.in_req = 1'b1;
        run_to(28);
        chk("fall0_hold", outs(), 4'b0010);
        run_to(30);
        bus.ack_0 = 1'b0;
        run_to(31);
        chk("idle_first", outs(), 4'b0000);
        run_to(32);
        chk("restart", outs(), 4'b1010);
        chk("no_out1", {3'b000, saw1}, 4'b0000);

        // err_clr coincident with timeout, then reset mid-RISE1
        do_reset();
        auto0 = 1'b0;
        bus.ack_0 = 1'b0;
        bus.in_req = 1'b1;
        run_to(71);
        bus.err_clr = 1'b1;
        run_to(72);
        bus.err_clr = 1'b0;
        chk("set_wins", outs(), 4'b1011);
        run_to(81);
        chk("rise1", outs(), 4'b1111);
        run_to(82);
        reset = 1'b0;
        #2;
        chk("async_rst", outs(), 4'b0000);
        auto0 = 1'b1;
        repeat (5) tick();
        chk("rst_hold", outs(), 4'b0000);
        reset = 1'b1;
        cyc = 0;
        run_to(6);
        chk("rst_pre", outs(), 4'b0000);
        run_to(7);
        chk("rst_out0", outs(), 4'b1010);
        run_to(20);
        chk("rst_out1", outs(), 4'b1110);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/fanout_release_sequencer.md
Name: fanout_release_sequencer

Overview:
- Sequences one request level onto two downstream consumers in a fixed order.
- Power-up order: out_0, then out_1. Power-down order: out_1, then out_0.
- Each step waits for the consumer's acknowledge, and steps are separated by a programmable gap.
- Replaces the plain one-to-two fanout wherever consumers need ordered, handshaked enable/release. The request input is asynchronous, so the block synchronizes and deglitches it.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on in_req (legal: >=2)
- FILTER, 4, consecutive cycles the synchronized input must differ from the filtered level before that level changes (>=1)
- GAP, 8, idle cycles between completing one consumer step and starting the next (>=1)
- TIMEOUT, 64, cycles to wait for an acknowledge before proceeding anyway and flagging an error (>=1)

Ports:
- clock  input  1  sole clock
- reset  input  1  asynchronous, active-low reset
- in_req  input  1  asynchronous request level
- ack_0  input  1  consumer 0 acknowledge level; follows out_0
- ack_1  input  1  consumer 1 acknowledge level; follows out_1
- err_clr  input  1  synchronous, single-cycle clear of err
- out_0  output  1  enable/release to consumer 0, registered
- out_1  output  1  enable/release to consumer 1, registered
- busy  output  1  high while a sequence is in progress (state not IDLE and not ON)
- err  output  1  sticky: an acknowledge timed out

Behaviour:
- Reset: asynchronous, active-low. While reset is low:
  - all synchronizer flops, the filtered level f, the counters and err are 0
  - state is IDLE
  - out_0 = out_1 = busy = 0
  - Deassertion resumes from IDLE; there is no mid-sequence recovery.
- Synchronizer: SYNC_STAGES flop chain, giving s.
- Filter:
  - A mismatch counter increments while s != f and is cleared when s == f.
  - When the counter reaches FILTER-1 with a mismatch still present, f takes s and the counter clears.
  - A pulse shorter than FILTER cycles never changes f.
- FSM states and outputs (outputs decoded from registered state, so they change on the cycle after the transition condition):
  - IDLE (0/0): f=1 -> RISE0.
  - RISE0 (1/0): ack_0=1 or timeout -> GAP_UP; f=0 -> FALL0.
  - GAP_UP (1/0): after GAP cycles -> RISE1; f=0 -> FALL0.
  - RISE1 (1/1): ack_1=1 or timeout -> ON; f=0 -> FALL1.
  - ON (1/1): f=0 -> FALL1.
  - FALL1 (1/0): ack_1=0 or timeout -> GAP_DN.
  - GAP_DN (1/0): after GAP cycles -> FALL0.
  - FALL0 (0/0): ack_0=0 or timeout -> IDLE.
- Abort rule: in the rising states, an f drop takes priority over an acknowledge in the same cycle.
- No abort on the falling path: f=1 during FALL1, GAP_DN or FALL0 is ignored until IDLE is reached. From IDLE, f=1 restarts the sequence on the next cycle.
- Counter:
  - One shared counter, cleared on every state entry, incrementing each cycle in wait/gap states.
  - Width is clog2(max(GAP,TIMEOUT)+1).
  - Gap complete: count == GAP-1.
  - Timeout: count == TIMEOUT-1 with the acknowledge not yet at its target level.
- err:
  - Set on any timeout; the transition proceeds in that same cycle.
  - err_clr clears err. If err_clr and a timeout occur in the same cycle, set wins.
- Latency:
  - in_req edge held stable -> out_0 change: SYNC_STAGES+FILTER+1 cycles.
  - ack_0 rise -> out_1 rise: GAP+2 cycles.
- Acknowledge already at its target level on state entry: the state is exited after exactly 1 cycle.

Test Plan:
- Power-up, defaults, acks respond 3 cycles after each out: in_req 0->1 at cycle 0 -> out_0=1 at cycle 7; out_1=1 at cycle 7+3+10=20; busy high from cycle 7 until ON is reached; err=0.
- Power-down from ON: in_req 1->0 -> out_1 falls after 7 cycles; out_0 falls GAP+2 cycles after ack_1 falls; ends in IDLE with busy=0.
- Glitch rejection: in_req high for 3 synchronized cycles (FILTER=4) -> out_0 stays 0, state stays IDLE.
- Timeout: ack_0 tied 0 -> out_0 rises; after 64 cycles err=1 and the sequence continues; out_1 rises after GAP; err_clr pulse -> err=0.
- Abort during GAP_UP: drop in_req -> out_1 never asserts; out_0 deasserts and the block returns to IDLE. Re-raising in_req during FALL0 -> IDLE is reached first, then RISE0 is entered.
- Reset low mid-RISE1 -> out_0=out_1=busy=err=0 immediately (asynchronous); after release with in_req high, the full sequence restarts from out_0.
